// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: MEM-stage FSM encoding and write-back select codes.
package cpu_pkg;

   localparam int CPU_DATA_W = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_LUI = 2'd2;
   localparam logic [1:0] WB_JAL = 2'd3;

   // jal outranks lui, which outranks a memory load, which outranks the ALU result
   function automatic logic [1:0] wb_code(input logic jal, input logic lui, input logic mem_to_reg);
      if (jal)             return WB_JAL;
      else if (lui)        return WB_LUI;
      else if (mem_to_reg) return WB_MEM;
      else                 return WB_ALU;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte for lb and extends it, word loads pass through.
module load_align #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr_lo,
   input  logic              lb,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] load_val
);

   logic [7:0] byte_sel;

   // little-endian byte pick, then sign or zero fill
   always_comb begin
      byte_sel = rdata[8*addr_lo +: 8];
      if (lb) load_val = {{(DATA_W-8){sign_ext & byte_sel[7]}}, byte_sel};
      else    load_val = rdata;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with a req/ack data-memory port.
//  state   | meaning
//  IDLE    | no access outstanding; non-memory ops pass through in one cycle
//  WAIT    | request held on dmem_*, instruction snapshot waiting for ack
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W    = CPU_DATA_W,
   parameter int DADDR_W   = 10,
   parameter bit LB_SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               flush_i,
   input  logic [4:0]         rw_i,
   input  logic               jal_i,
   input  logic               lui_i,
   input  logic               lb_i,
   input  logic               MemToReg_i,
   input  logic               Memwrite_i,
   input  logic               Regwrite_i,
   input  logic [DATA_W-1:0]  B_i,
   input  logic [DATA_W-1:0]  Imm_i,
   input  logic [DATA_W-1:0]  PC_i,
   input  logic [DATA_W-1:0]  ALU_i,
   output logic               stall_o,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ack,
   output logic               valid_o,
   output logic               Regwrite_o,
   output logic [4:0]         rw_o,
   output logic [DATA_W-1:0]  wb_data_o
);

   logic [0:0]        state;
   logic              live;
   logic              mem_op;

   logic [4:0]        s_rw;
   logic              s_regwrite;
   logic              s_store;
   logic              s_jal;
   logic              s_lui;
   logic              s_lb;
   logic              s_mem_to_reg;
   logic [DATA_W-1:0] s_pc;
   logic [15:0]       s_imm;
   logic [DATA_W-1:0] s_alu;

   logic              sel_jal;
   logic              sel_lui;
   logic              sel_mtr;
   logic [DATA_W-1:0] sel_pc;
   logic [15:0]       sel_imm;
   logic [DATA_W-1:0] sel_alu;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] wb_next;

   logic              unused_imm_hi;
   assign unused_imm_hi = ^Imm_i[DATA_W-1:16];

   assign live   = valid_i & ~flush_i;
   assign mem_op = live & (MemToReg_i | Memwrite_i);

   // upstream hold: issuing a memory op, or waiting on an ack that has not arrived
   always_comb begin
      stall_o = 1'b0;
      if (rst) begin
         if (state == ST_IDLE) stall_o = mem_op;
         else                  stall_o = ~dmem_ack;
      end
   end

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata    (dmem_rdata),
      .addr_lo  (s_alu[1:0]),
      .lb       (s_lb),
      .sign_ext (LB_SIGNED),
      .load_val (load_val)
   );

   // write-back value from live inputs in IDLE, from the snapshot in WAIT
   always_comb begin
      sel_jal = jal_i;
      sel_lui = lui_i;
      sel_mtr = 1'b0;
      sel_pc  = PC_i;
      sel_imm = Imm_i[15:0];
      sel_alu = ALU_i;
      if (state == ST_WAIT) begin
         sel_jal = s_jal;
         sel_lui = s_lui;
         sel_mtr = s_mem_to_reg;
         sel_pc  = s_pc;
         sel_imm = s_imm;
         sel_alu = s_alu;
      end
      case (wb_code(sel_jal, sel_lui, sel_mtr))
         WB_JAL:  wb_next = sel_pc + DATA_W'(1);
         WB_LUI:  wb_next = {{(DATA_W-32){1'b0}}, sel_imm, 16'h0000};
         WB_MEM:  wb_next = load_val;
         default: wb_next = sel_alu;
      endcase
   end

   // FSM, memory request port, snapshot and MEM/WB register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         valid_o      <= 1'b0;
         Regwrite_o   <= 1'b0;
         rw_o         <= '0;
         wb_data_o    <= '0;
         s_rw         <= '0;
         s_regwrite   <= 1'b0;
         s_store      <= 1'b0;
         s_jal        <= 1'b0;
         s_lui        <= 1'b0;
         s_lb         <= 1'b0;
         s_mem_to_reg <= 1'b0;
         s_pc         <= '0;
         s_imm        <= '0;
         s_alu        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_op) begin
                  state        <= ST_WAIT;
                  dmem_req     <= 1'b1;
                  dmem_we      <= Memwrite_i;
                  dmem_addr    <= ALU_i[DADDR_W+1:2];
                  dmem_wdata   <= B_i;
                  valid_o      <= 1'b0;
                  Regwrite_o   <= 1'b0;
                  s_rw         <= rw_i;
                  s_regwrite   <= Regwrite_i;
                  s_store      <= Memwrite_i & ~MemToReg_i;
                  s_jal        <= jal_i;
                  s_lui        <= lui_i;
                  s_lb         <= lb_i;
                  s_mem_to_reg <= MemToReg_i;
                  s_pc         <= PC_i;
                  s_imm        <= Imm_i[15:0];
                  s_alu        <= ALU_i;
               end else begin
                  valid_o    <= live;
                  Regwrite_o <= Regwrite_i & live & (rw_i != 5'd0);
                  rw_o       <= rw_i;
                  wb_data_o  <= wb_next;
               end
            end
            default: begin
               if (dmem_ack) begin
                  state      <= ST_IDLE;
                  dmem_req   <= 1'b0;
                  valid_o    <= 1'b1;
                  Regwrite_o <= s_regwrite & ~s_store & (s_rw != 5'd0);
                  rw_o       <= s_rw;
                  wb_data_o  <= wb_next;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: drivers push expected WB bundles, a monitor pops on valid_o.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, flush_i;
   logic [4:0]  rw_i;
   logic        jal_i, lui_i, lb_i, MemToReg_i, Memwrite_i, Regwrite_i;
   logic [31:0] B_i, Imm_i, PC_i, ALU_i;
   logic        stall_o, dmem_req, dmem_we;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        valid_o, Regwrite_o;
   logic [4:0]  rw_o;
   logic [31:0] wb_data_o;

   typedef struct packed {
      logic [4:0]  rw;
      logic        rwen;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  n_pass = 0;
   int  n_total = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .DADDR_W(10), .LB_SIGNED(1'b1)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .rw_i(rw_i),
      .jal_i(jal_i), .lui_i(lui_i), .lb_i(lb_i), .MemToReg_i(MemToReg_i),
      .Memwrite_i(Memwrite_i), .Regwrite_i(Regwrite_i), .B_i(B_i), .Imm_i(Imm_i),
      .PC_i(PC_i), .ALU_i(ALU_i), .stall_o(stall_o), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_o(valid_o),
      .Regwrite_o(Regwrite_o), .rw_o(rw_o), .wb_data_o(wb_data_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // monitor: every live WB bundle must match the oldest expected entry
   always @(negedge clk) begin
      if (rst === 1'b1 && valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid_o: got rw=%0d data=0x%08h expected no output", rw_o, wb_data_o);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rw", {27'd0, rw_o}, {27'd0, e.rw});
            chk("wb_regwrite", {31'd0, Regwrite_o}, {31'd0, e.rwen});
            chk("wb_data", wb_data_o, e.data);
         end
      end
   end

   task automatic clear_inputs();
      valid_i = 0; flush_i = 0; rw_i = 0; jal_i = 0; lui_i = 0; lb_i = 0;
      MemToReg_i = 0; Memwrite_i = 0; Regwrite_i = 0;
      B_i = 0; Imm_i = 0; PC_i = 0; ALU_i = 0;
   endtask

   task automatic push(input logic [4:0] rw, input logic rwen, input logic [31:0] data);
      wb_t e;
      e.rw = rw; e.rwen = rwen; e.data = data;
      exp_q.push_back(e);
   endtask

   // single-cycle (non-memory) instruction
   task automatic alu_op(input logic [4:0] rw, input logic rwe, input logic jal, input logic lui,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                         input logic exp_rwen, input logic [31:0] exp_data);
      @(negedge clk);
      valid_i = 1; rw_i = rw; Regwrite_i = rwe; jal_i = jal; lui_i = lui;
      ALU_i = alu; PC_i = pc; Imm_i = imm;
      push(rw, exp_rwen, exp_data);
      #1 chk("alu_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      clear_inputs();
   endtask

   // memory instruction; ack arrives after 'waits' WAIT cycles without it
   task automatic mem_op(input logic [4:0] rw, input logic rwe, input logic mtr, input logic mw,
                         input logic lb, input logic [31:0] alu, input logic [31:0] b,
                         input logic [31:0] rdata, input int waits, input logic flush_in_wait,
                         input logic [9:0] exp_addr, input logic exp_rwen, input logic [31:0] exp_data);
      int stalls;
      stalls = 0;
      @(negedge clk);
      valid_i = 1; rw_i = rw; Regwrite_i = rwe; MemToReg_i = mtr; Memwrite_i = mw;
      lb_i = lb; ALU_i = alu; B_i = b;
      push(rw, exp_rwen, exp_data);
      #1 if (stall_o) stalls++;
      @(negedge clk);
      clear_inputs();
      flush_i = flush_in_wait;
      chk("dmem_req", {31'd0, dmem_req}, 32'd1);
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, mw});
      chk("dmem_addr", {22'd0, dmem_addr}, {22'd0, exp_addr});
      if (mw) chk("dmem_wdata", dmem_wdata, b);
      for (int i = 0; i < waits; i++) begin
         #1 if (stall_o) stalls++;
         @(negedge clk);
         chk("valid_o_in_wait", {31'd0, valid_o}, 32'd0);
      end
      dmem_ack = 1; dmem_rdata = rdata;
      #1 chk("stall_on_ack", {31'd0, stall_o}, 32'd0);
      chk("stall_cycles", stalls, waits + 1);
      @(negedge clk);
      dmem_ack = 0; dmem_rdata = 32'h0; flush_i = 0;
      chk("dmem_req_done", {31'd0, dmem_req}, 32'd0);
   endtask

   initial begin
      clear_inputs();
      dmem_ack = 0; dmem_rdata = 0;
      rst = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_regwrite", {31'd0, Regwrite_o}, 32'd0);
      chk("rst_wb_data", wb_data_o, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      rst = 1;

      // ALU op, jal, lui, write to r0
      alu_op(5'd5, 1, 0, 0, 32'h1234, 32'h0, 32'h0, 1, 32'h0000_1234);
      alu_op(5'd31, 1, 1, 0, 32'h9999, 32'h40, 32'h0, 1, 32'h0000_0041);
      alu_op(5'd3, 1, 0, 1, 32'h9999, 32'h0, 32'h0000_ABCD, 1, 32'hABCD_0000);
      alu_op(5'd0, 1, 0, 0, 32'h7777, 32'h0, 32'h0, 0, 32'h0000_7777);

      // word load with three ack-less WAIT cycles
      mem_op(5'd6, 1, 1, 0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, 0, 10'd4, 1, 32'hDEAD_BEEF);
      // lb at byte 3 (sign-extended 0x80) and byte 0 (0x01); flush during WAIT ignored
      mem_op(5'd7, 1, 1, 0, 1, 32'h13, 32'h0, 32'h80FF_7F01, 0, 1, 10'd4, 1, 32'hFFFF_FF80);
      mem_op(5'd8, 1, 1, 0, 1, 32'h10, 32'h0, 32'h80FF_7F01, 1, 0, 10'd4, 1, 32'h0000_0001);
      // store: Regwrite forced low even if requested, WB value is the ALU address
      mem_op(5'd9, 1, 0, 1, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 2, 0, 10'd8, 0, 32'h0000_0020);

      // flushed instruction must produce nothing
      @(negedge clk);
      valid_i = 1; flush_i = 1; Regwrite_i = 1; rw_i = 5'd4; MemToReg_i = 1; ALU_i = 32'h10;
      #1 chk("flush_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      clear_inputs();
      chk("flush_no_req", {31'd0, dmem_req}, 32'd0);

      // stray ack in IDLE ignored
      dmem_ack = 1; dmem_rdata = 32'h5555_5555;
      @(negedge clk);
      dmem_ack = 0;
      chk("idle_ack_ignored", {31'd0, valid_o}, 32'd0);

      // reset while waiting on a load
      @(negedge clk);
      valid_i = 1; Regwrite_i = 1; rw_i = 5'd10; MemToReg_i = 1; ALU_i = 32'h30;
      @(negedge clk);
      clear_inputs();
      rst = 0;
      #1 chk("rst_wait_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      chk("rst_wait_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_wait_valid", {31'd0, valid_o}, 32'd0);
      rst = 1;
      dmem_ack = 1; dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      dmem_ack = 0;
      chk("late_ack_valid", {31'd0, valid_o}, 32'd0);
      chk("late_ack_req", {31'd0, dmem_req}, 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. It consumes the combinational EX/MEM bundle and drives the data-memory request/acknowledge handshake.
- Handles lb byte extraction and selects the final write-back value (jal / lui / mem / ALU). Registers the result for the register-file write port.
- Generates stall_o back to upstream stages while a memory access is outstanding.

Parameters:
- DATA_W, 32, datapath width
- DADDR_W, 10, data-memory word-address width; word address = ALU_i[DADDR_W+1:2]
- LB_SIGNED, 1, 1 = lb sign-extends the byte, 0 = zero-extends

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- valid_i  in  1  EX/MEM bundle holds a live instruction
- flush_i  in  1  kill the instruction presented this cycle
- rw_i  in  5  destination register
- jal_i, lui_i, lb_i, MemToReg_i, Memwrite_i, Regwrite_i  in  1 each  control from EX/MEM
- B_i, Imm_i, PC_i, ALU_i  in  DATA_W each  store data, immediate, PC, ALU result/byte address
- stall_o  out  1  upstream must hold its state this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  DADDR_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  in  1  request completed this cycle
- valid_o  out  1  WB bundle is live
- Regwrite_o  out  1  register-file write enable
- rw_o  out  5  write register
- wb_data_o  out  DATA_W  write-back value

Behaviour:
- mem_op = valid_i & ~flush_i & (MemToReg_i | Memwrite_i).
- FSM states: IDLE, WAIT.
- IDLE, mem_op=0:
  - stall_o=0.
  - Next edge: valid_o <= valid_i & ~flush_i.
  - Regwrite_o <= Regwrite_i & valid & (rw_i!=0).
  - rw_o, wb_data_o latched.
  - Latency 1 cycle.
- IDLE, mem_op=1:
  - stall_o=1.
  - Next edge: go to WAIT, dmem_req<=1, and register dmem_we/dmem_addr/dmem_wdata. These are held stable until ack.
  - Snapshot rw, Regwrite, jal, lui, lb, MemToReg, PC, Imm and ALU[1:0] into internal registers.
  - valid_o<=0.
- WAIT:
  - stall_o = ~dmem_ack.
  - If dmem_ack=0: stay in WAIT; valid_o stays 0.
  - On dmem_ack=1: next edge goes to IDLE, dmem_req<=0, and the WB registers load from the snapshot. wb_data_o uses dmem_rdata for loads. valid_o<=1.
  - Minimum memory instruction latency: 2 cycles (ack in the first WAIT cycle).
- Write-back select, priority order:
  - jal: PC+1
  - lui: {Imm[15:0],16'h0}
  - MemToReg & lb: byte ext
  - MemToReg: rdata
  - else: ALU
- lb byte select:
  - Byte = rdata[8*addr[1:0] +: 8], little-endian.
  - Extended per LB_SIGNED.
  - Word loads ignore addr[1:0].
- Stores (Memwrite only): Regwrite_o forced 0; valid_o still pulses 1 on completion.
- Writes to r0 always produce Regwrite_o=0.
- dmem_ack in IDLE is ignored.
- flush_i while in WAIT has no effect; the access in flight completes.
- rst=0 (any state, including WAIT):
  - Next edge: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, valid_o=0, Regwrite_o=0, rw_o=0, wb_data_o=0.
  - An ack arriving after reset is ignored.
- stall_o is combinational from state, valid_i, flush_i, controls and dmem_ack. It is 0 while rst=0.

Decomposition:
- Shared package (cpu_pkg): FSM state encoding (ST_IDLE, ST_WAIT), write-back select constants, DATA_W default.
- One sub-module, load_align: combinational byte select and extension (rdata, addr[1:0], lb, signed) -> load value. It is reused by later lh/lbu work.

Test Plan:
- ALU op, Regwrite_i=1, rw_i=5, ALU_i=0x1234, valid_i=1 -> next cycle: valid_o=1, Regwrite_o=1, rw_o=5, wb_data_o=0x1234, stall_o=0 throughout.
- Word load, ALU_i=0x10, ack after 3 WAIT cycles, rdata=0xDEADBEEF:
  - dmem_addr=4.
  - stall_o high for 4 cycles.
  - wb_data_o=0xDEADBEEF one cycle after ack.
- lb, ALU_i=0x13, rdata=0x80FF7F01, LB_SIGNED=1 -> wb_data_o=0xFFFFFF80. With ALU_i=0x10 -> 0x00000001.
- Store, B_i=0xCAFEF00D, ALU_i=0x20, Regwrite_i=0:
  - dmem_we=1, dmem_wdata=0xCAFEF00D, dmem_addr=8.
  - After ack: valid_o=1, Regwrite_o=0.
- jal with PC_i=0x40 -> wb_data_o=0x41. lui with Imm_i=0x0000ABCD -> 0xABCD0000. rw_i=0 with Regwrite_i=1 -> Regwrite_o=0.
- rst=0 asserted during WAIT:
  - Next cycle: dmem_req=0, valid_o=0, stall_o=0.
  - Later dmem_ack=1 produces no valid_o.
